// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the word-addressed memory burst master.
//   access_size_e : host command size encoding (1/4/8/16 words)
//   mst_state_e   : burst master FSM states
//   words_of()    : word count carried by a command size
//   MEM_WORD_BYTES: byte stride between consecutive memory words
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    AS_1  = 2'b00,
    AS_4  = 2'b01,
    AS_8  = 2'b10,
    AS_16 = 2'b11
  } access_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_CAPT,
    ST_WR
  } mst_state_e;

  // Number of words moved by a command of the given size.
  function automatic logic [4:0] words_of(input access_size_e size);
    logic [4:0] n;
    unique case (size)
      AS_1:    n = 5'd1;
      AS_4:    n = 5'd4;
      AS_8:    n = 5'd8;
      default: n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_word_buf.sv
// ---------------------------------------------------------------------------
// mem_word_buf
// DEPTH x WIDTH word buffer with one synchronous write port and one
// combinational read port. Contents are never cleared.
// Ports:
//   i_clk    clock
//   i_we     write strobe
//   i_widx   write index
//   i_wdata  write data
//   i_ridx   read index
//   o_rdata  read data, combinational from i_ridx
// ---------------------------------------------------------------------------
module mem_word_buf
  import mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = MEM_WORD_BYTES * 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Single write port; storage has no reset so buffered data survives
  // both idle periods and a reset of the surrounding controller.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/mem_burst_master.sv
// ---------------------------------------------------------------------------
// mem_burst_master
// Initiator for the word-addressed memory. Accepts 1/4/8/16-word read or
// write commands from a host and drives the memory pins. Reads are split
// into sub-bursts of at most SUB_BURST words and land in a read buffer;
// writes are issued as back-to-back single-word accesses from a write buffer.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_cmd_start/_rd_wr/_size  command strobe, direction (1=read), size code
//   i_cmd_addr                byte address, bits [1:0] ignored
//   o_cmd_ready               IDLE and memory not busy
//   o_cmd_done, o_cmd_err     one-cycle completion / protocol-error pulses
//   i_wbuf_we/_idx/_data      write-buffer load port (IDLE only)
//   i_rbuf_idx, o_rbuf_data   read-buffer combinational read port
//   o_mem_*                   registered memory request pins
//   i_mem_busy, i_mem_data_out memory status and read data
// ---------------------------------------------------------------------------
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int BUF_DEPTH  = 16,
  parameter int SUB_BURST  = 4,
  parameter bit CHECK_BUSY = 1'b1,
  localparam int IDX_W = $clog2(BUF_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_start,
  input  logic             i_cmd_rd_wr,
  input  logic [1:0]       i_cmd_size,
  input  logic [31:0]      i_cmd_addr,
  output logic             o_cmd_ready,
  output logic             o_cmd_done,
  output logic             o_cmd_err,
  input  logic             i_wbuf_we,
  input  logic [IDX_W-1:0] i_wbuf_idx,
  input  logic [31:0]      i_wbuf_data,
  input  logic [IDX_W-1:0] i_rbuf_idx,
  output logic [31:0]      o_rbuf_data,
  output logic             o_mem_enable,
  output logic             o_mem_rd_wr,
  output logic [1:0]       o_mem_access_size,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_data_in,
  input  logic             i_mem_busy,
  input  logic [31:0]      i_mem_data_out
);

  mst_state_e       r_state, w_state_next;
  access_size_e     r_size, w_size;
  logic [31:0]      r_base, w_base;
  logic [IDX_W-1:0] r_cnt, w_cnt_next;

  logic             r_mem_enable, r_mem_rd_wr;
  access_size_e     r_mem_as;
  logic [31:0]      r_mem_addr, r_mem_data_in;
  logic             r_cmd_done, r_cmd_err;

  logic             w_en_n, w_rw_n, w_done_n, w_err_n;
  access_size_e     w_as_n;
  logic [31:0]      w_addr_n, w_data_n;

  logic             w_accept, w_last, w_last_in_burst;
  access_size_e     w_burst_as;
  logic             w_wbuf_we, w_rbuf_we;
  logic [31:0]      w_wbuf_rd, w_wr_word;
  logic [1:0]       w_unused_addr_bits;

  assign w_unused_addr_bits = i_cmd_addr[1:0];

  // While idle the command inputs are the live source of size and base so
  // the very first request can be registered on the accepting edge.
  assign w_size = (r_state == ST_IDLE) ? access_size_e'(i_cmd_size) : r_size;
  assign w_base = (r_state == ST_IDLE) ? {i_cmd_addr[31:2], 2'b00} : r_base;

  assign o_cmd_ready = (r_state == ST_IDLE) && !i_mem_busy;
  assign w_accept    = o_cmd_ready && i_cmd_start;

  assign w_last          = (5'(r_cnt) == (words_of(w_size) - 5'd1));
  assign w_last_in_burst = w_last || (((int'(r_cnt) + 1) % SUB_BURST) == 0);
  assign w_burst_as      = (words_of(w_size) == 5'd1) ? AS_1 : AS_4;

  // Next-state and next-pin logic. Pin values are computed for the state
  // being entered and registered, so a request appears on the pins in the
  // cycle right after the decision edge. Read enables are single-cycle:
  // holding enable would abort the memory burst.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_en_n       = 1'b0;
    w_rw_n       = 1'b0;
    w_as_n       = AS_1;
    w_done_n     = 1'b0;
    w_err_n      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_next = '0;
          w_en_n     = 1'b1;
          if (i_cmd_rd_wr) begin
            w_state_next = ST_RD_ISSUE;
            w_rw_n       = 1'b1;
            w_as_n       = w_burst_as;
          end else begin
            w_state_next = ST_WR;
          end
        end
      end
      ST_RD_ISSUE: begin
        w_state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // The memory must have raised busy after sampling the request.
        if (CHECK_BUSY && !i_mem_busy) begin
          w_done_n     = 1'b1;
          w_err_n      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RD_CAPT;
        end
      end
      ST_RD_CAPT: begin
        if (w_last) begin
          w_done_n     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last_in_burst) begin
            w_state_next = ST_RD_ISSUE;
            w_en_n       = 1'b1;
            w_rw_n       = 1'b1;
            w_as_n       = w_burst_as;
          end
        end
      end
      ST_WR: begin
        if (w_last) begin
          w_done_n     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          w_en_n     = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_addr_n = w_en_n ? (w_base + (32'(w_cnt_next) * 32'(MEM_WORD_BYTES))) : '0;

  // A buffer load in the same cycle as the write command must win, so the
  // incoming word bypasses the buffer when it targets the word being issued.
  assign w_wbuf_we = i_wbuf_we && (r_state == ST_IDLE);
  assign w_wr_word = (w_wbuf_we && (i_wbuf_idx == w_cnt_next)) ? i_wbuf_data : w_wbuf_rd;
  assign w_data_n  = (w_en_n && !w_rw_n) ? w_wr_word : '0;

  assign w_rbuf_we = (r_state == ST_RD_CAPT) && !i_reset;

  // State, counters and all registered outputs. Reset clears control and
  // pins but leaves buffer contents alone.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_size        <= AS_1;
      r_base        <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_rd_wr   <= 1'b0;
      r_mem_as      <= AS_1;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_cmd_done    <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      if (w_accept) begin
        r_size <= w_size;
        r_base <= w_base;
      end
      r_mem_enable  <= w_en_n;
      r_mem_rd_wr   <= w_rw_n;
      r_mem_as      <= w_as_n;
      r_mem_addr    <= w_addr_n;
      r_mem_data_in <= w_data_n;
      r_cmd_done    <= w_done_n;
      r_cmd_err     <= w_err_n;
    end
  end

  assign o_mem_enable      = r_mem_enable;
  assign o_mem_rd_wr       = r_mem_rd_wr;
  assign o_mem_access_size = r_mem_as;
  assign o_mem_addr        = r_mem_addr;
  assign o_mem_data_in     = r_mem_data_in;
  assign o_cmd_done        = r_cmd_done;
  assign o_cmd_err         = r_cmd_err;

  mem_word_buf #(.DEPTH(BUF_DEPTH), .WIDTH(32)) u_rbuf (
    .i_clk   (i_clk),
    .i_we    (w_rbuf_we),
    .i_widx  (r_cnt),
    .i_wdata (i_mem_data_out),
    .i_ridx  (i_rbuf_idx),
    .o_rdata (o_rbuf_data)
  );

  mem_word_buf #(.DEPTH(BUF_DEPTH), .WIDTH(32)) u_wbuf (
    .i_clk   (i_clk),
    .i_we    (w_wbuf_we),
    .i_widx  (i_wbuf_idx),
    .i_wdata (i_wbuf_data),
    .i_ridx  (w_cnt_next),
    .o_rdata (w_wbuf_rd)
  );

endmodule
